count_down_timer: RTL and testbench
===================================

Name: count_down_timer

Overview:
Loadable down-counter/timer: the decrementing counterpart of the team's free-running 4-bit up-counter. A period value is loaded through a valid/ready handshake. The block counts down on enabled cycles and pulses done at terminal count, then either stops or auto-reloads. It serves as the general-purpose timeout/tick generator in the same design.

Parameters:
WIDTH, 4, width of counter, period register and load_val.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
load_valid  in  1  period load request.
load_ready  out  1  block can accept a load; high only in IDLE.
load_val  in  WIDTH  period to load; sampled when load_valid && load_ready.
en  in  1  count enable; when low in RUN, val holds.
reload  in  1  auto-reload mode; sampled at the terminal-count edge.
stop  in  1  synchronous abort; forces IDLE.
val  out  WIDTH  current count (registered).
busy  out  1  high in RUN.
done  out  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, val=0, period=0, done=0, busy=0. load_ready=1 from the first cycle after release.
- States:
  - IDLE: busy=0, load_ready=1, val holds.
  - RUN: busy=1, load_ready=0.
- Load is accepted on an edge with load_valid=1 and load_ready=1:
  - period <= load_val and val <= load_val at that edge.
  - load_val>0: next state RUN.
  - load_val=0: stay IDLE, val=0, done=1 for the following cycle (degenerate immediate expiry).
- RUN, en=1, val>1: val <= val-1.
- RUN, en=1, val==1 (terminal edge):
  - reload=0: val <= 0, state <= IDLE, done <= 1.
  - reload=1: val <= period, stay RUN, done <= 1.
  - Period N with reload=1 and en held high gives one done pulse every N cycles.
- RUN, en=0: val and state hold; done=0.
- done is high exactly one cycle, coincident with the first cycle val shows 0 (or the reloaded period). It is never high two consecutive cycles unless period=1 with reload=1, in which case done stays high continuously.
- stop=1 in RUN: state <= IDLE, val holds current value, done=0. stop beats a simultaneous terminal edge (no done, no reload).
- stop=1 in IDLE has no effect. stop=1 with a simultaneous load: the load is accepted and stop is ignored.
- load_valid in RUN is ignored (load_ready=0). The requester must hold load_valid until load_ready.
- Arithmetic: unsigned, modulo 2^WIDTH. val never underflows, because the 1->0 step is the terminal edge and 0 is never decremented.
- Reset mid-run discards period and count immediately; no done is generated.
- Latency: load to first decrement = 1 cycle (the value is visible the cycle after acceptance; the decrement happens on the next enabled edge).

Test Plan:
- Reset then load_val=4, reload=0, en=1 -> val 4,3,2,1,0; done high only in the val=0 cycle; busy falls with done; load_ready returns to 1.
- load_val=3, reload=1, en=1 for 10 cycles -> val 3,2,1,3,2,1,3,...; done pulses every 3rd cycle; busy stays 1.
- load_val=5, en toggled 1,0,0,1,1,... -> val holds during en=0; done only after 5 enabled cycles.
- load_val=2, stop asserted on the edge where val==1 -> IDLE, val=1, done never asserted.
- load_val=0 -> done pulse the next cycle, val=0, busy never asserted.
- Assert rst=0 asynchronously mid-count (val=6, WIDTH=4, loaded 15) -> val=0, done=0, busy=0 immediately without a clock; load with load_valid held during RUN is accepted only once IDLE is reached.

Source files
------------

// File: rtl/count_down_timer_if.sv
// Load channel for count_down_timer: period value offered through a valid/ready handshake.
interface count_down_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_val;

    // Requester side: offers a period and waits for acceptance.
    modport master (
        output load_valid,
        output load_val,
        input  load_ready
    );

    // Timer side: accepts a period when idle.
    modport slave (
        input  load_valid,
        input  load_val,
        output load_ready
    );
endinterface

// File: rtl/count_down_timer.sv
// Loadable down-counter: counts a loaded period down to zero on enabled cycles,
// pulses done at terminal count, then stops or auto-reloads.
module count_down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    count_down_timer_if.slave   load_if,
    input  logic                en,
    input  logic                reload,
    input  logic                stop,
    output logic [WIDTH-1:0]    val,
    output logic                busy,
    output logic                done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] period;
    logic             ready;
    logic             accept_c;

    assign load_if.load_ready = ready;
    assign accept_c           = load_if.load_valid && ready;

    // Control FSM with registered count, period and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            val    <= '0;
            period <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    // A load wins over stop; a zero period expires immediately.
                    if (accept_c) begin
                        period <= WIDTH'(load_if.load_val);
                        val    <= WIDTH'(load_if.load_val);
                        if (load_if.load_val != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            ready <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort keeps the current count and suppresses any terminal pulse.
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else if (en) begin
                        if (val > WIDTH'(1)) begin
                            val <= val - WIDTH'(1);
                        end else begin
                            // Terminal edge: the 1->0 step never underflows.
                            done <= 1'b1;
                            if (reload) begin
                                val <= period;
                            end else begin
                                val   <= '0;
                                state <= IDLE;
                                busy  <= 1'b0;
                                ready <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_down_timer.sv
// Directed self-checking bench for count_down_timer (WIDTH=4).
module tb_count_down_timer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             reload;
    logic             stop;
    logic [WIDTH-1:0] val;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    count_down_timer_if #(.WIDTH(WIDTH)) lif ();

    count_down_timer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .load_if (lif),
        .en      (en),
        .reload  (reload),
        .stop    (stop),
        .val     (val),
        .busy    (busy),
        .done    (done)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer a period and step over the accepting edge.
    task automatic do_load(input logic [WIDTH-1:0] v);
        lif.load_valid = 1'b1;
        lif.load_val   = v;
        tick();
        lif.load_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if (val !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_outputs: val=%0d busy=%0b done=%0b, expected 0/0/0", val, busy, done);
            n_fail++;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (lif.load_ready !== 1'b0) begin
            $display("FAIL reset_ready: load_ready=%0b expected 0", lif.load_ready);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (lif.load_ready !== 1'b1 || busy !== 1'b0 || val !== 4'd0) begin
            $display("FAIL after_release: ready=%0b busy=%0b val=%0d, expected 1/0/0", lif.load_ready, busy, val);
            n_fail++;
        end
    endtask

    task automatic test_oneshot;
        logic [WIDTH-1:0] exp_val [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        logic             exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic             exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        en = 1'b1;
        reload = 1'b0;
        do_load(4'd4);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (val !== exp_val[i] || done !== exp_done[i] || busy !== exp_busy[i]) begin
                $display("FAIL oneshot[%0d]: val=%0d done=%0b busy=%0b, expected %0d/%0b/%0b",
                         i, val, done, busy, exp_val[i], exp_done[i], exp_busy[i]);
                n_fail++;
            end
            if (i < 4) tick();
        end
        n_checks++;
        if (lif.load_ready !== 1'b1) begin
            $display("FAIL oneshot_ready: load_ready=%0b expected 1", lif.load_ready);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || val !== 4'd0) begin
            $display("FAIL oneshot_after: done=%0b val=%0d, expected 0/0", done, val);
            n_fail++;
        end
    endtask

    task automatic test_reload;
        logic [WIDTH-1:0] exp_val [10] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
        logic             exp_done [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        en = 1'b1;
        reload = 1'b1;
        do_load(4'd3);
        n_checks++;
        if (val !== 4'd3 || busy !== 1'b1) begin
            $display("FAIL reload_load: val=%0d busy=%0b, expected 3/1", val, busy);
            n_fail++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (val !== exp_val[i] || done !== exp_done[i] || busy !== 1'b1) begin
                $display("FAIL reload[%0d]: val=%0d done=%0b busy=%0b, expected %0d/%0b/1",
                         i, val, done, busy, exp_val[i], exp_done[i]);
                n_fail++;
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        reload = 1'b0;
        n_checks++;
        if (val !== 4'd2 || busy !== 1'b0 || done !== 1'b0 || lif.load_ready !== 1'b1) begin
            $display("FAIL reload_stop: val=%0d busy=%0b done=%0b ready=%0b, expected 2/0/0/1",
                     val, busy, done, lif.load_ready);
            n_fail++;
        end
    endtask

    task automatic test_enable;
        logic             en_pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [WIDTH-1:0] exp_val [7] = '{4'd4, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        logic             exp_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        reload = 1'b0;
        en = 1'b1;
        do_load(4'd5);
        n_checks++;
        if (val !== 4'd5) begin
            $display("FAIL enable_load: val=%0d expected 5", val);
            n_fail++;
        end
        for (int i = 0; i < 7; i++) begin
            en = en_pat[i];
            tick();
            n_checks++;
            if (val !== exp_val[i] || done !== exp_done[i]) begin
                $display("FAIL enable[%0d]: val=%0d done=%0b, expected %0d/%0b",
                         i, val, done, exp_val[i], exp_done[i]);
                n_fail++;
            end
        end
        en = 1'b1;
    endtask

    task automatic test_stop_terminal;
        en = 1'b1;
        reload = 1'b1;
        do_load(4'd2);
        tick();
        n_checks++;
        if (val !== 4'd1 || busy !== 1'b1) begin
            $display("FAIL stop_pre: val=%0d busy=%0b, expected 1/1", val, busy);
            n_fail++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (val !== 4'd1 || busy !== 1'b0 || done !== 1'b0 || lif.load_ready !== 1'b1) begin
            $display("FAIL stop_terminal: val=%0d busy=%0b done=%0b ready=%0b, expected 1/0/0/1",
                     val, busy, done, lif.load_ready);
            n_fail++;
        end
        tick();
        n_checks++;
        if (val !== 4'd1 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL stop_hold: val=%0d done=%0b busy=%0b, expected 1/0/0", val, done, busy);
            n_fail++;
        end
        reload = 1'b0;
    endtask

    task automatic test_stop_with_load;
        en = 1'b1;
        stop = 1'b1;
        do_load(4'd2);
        stop = 1'b0;
        n_checks++;
        if (val !== 4'd2 || busy !== 1'b1) begin
            $display("FAIL stop_load: val=%0d busy=%0b, expected 2/1", val, busy);
            n_fail++;
        end
        tick();
        tick();
        n_checks++;
        if (val !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL stop_load_end: val=%0d done=%0b busy=%0b, expected 0/1/0", val, done, busy);
            n_fail++;
        end
    endtask

    task automatic test_zero_load;
        do_load(4'd0);
        n_checks++;
        if (val !== 4'd0 || done !== 1'b1 || busy !== 1'b0 || lif.load_ready !== 1'b1) begin
            $display("FAIL zero_load: val=%0d done=%0b busy=%0b ready=%0b, expected 0/1/0/1",
                     val, done, busy, lif.load_ready);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL zero_after: done=%0b busy=%0b, expected 0/0", done, busy);
            n_fail++;
        end
    endtask

    task automatic test_async_reset;
        en = 1'b1;
        reload = 1'b0;
        do_load(4'd15);
        for (int i = 0; i < 9; i++) tick();
        n_checks++;
        if (val !== 4'd6 || busy !== 1'b1) begin
            $display("FAIL async_pre: val=%0d busy=%0b, expected 6/1", val, busy);
            n_fail++;
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (val !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL async_reset: val=%0d done=%0b busy=%0b, expected 0/0/0", val, done, busy);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (lif.load_ready !== 1'b1 || val !== 4'd0) begin
            $display("FAIL async_release: ready=%0b val=%0d, expected 1/0", lif.load_ready, val);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] exp_val [4] = '{4'd2, 4'd1, 4'd0, 4'd7};
        logic             exp_busy [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        en = 1'b1;
        reload = 1'b0;
        do_load(4'd3);
        lif.load_valid = 1'b1;
        lif.load_val   = 4'd7;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (val !== exp_val[i] || busy !== exp_busy[i]) begin
                $display("FAIL held_load[%0d]: val=%0d busy=%0b, expected %0d/%0b",
                         i, val, busy, exp_val[i], exp_busy[i]);
                n_fail++;
            end
        end
        lif.load_valid = 1'b0;
        tick();
        n_checks++;
        if (val !== 4'd6) begin
            $display("FAIL held_load_run: val=%0d expected 6", val);
            n_fail++;
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        reload = 1'b0;
        stop = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_val = '0;
        n_checks = 0;
        n_fail = 0;

        test_reset();
        test_oneshot();
        test_reload();
        test_enable();
        test_stop_terminal();
        test_stop_with_load();
        test_zero_load();
        test_async_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
